// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the motor ramp controller.
package motor_ctrl_pkg;

    localparam int DEF_LENGTH = 10;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_REV_DOWN,
        ST_DEAD,
        ST_BRAKE
    } state_t;

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, cleared only by reset.
module ramp_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..TICK_DIV-1 and wrap.
    always_ff @(posedge clk) begin
        if (!rst_n)           cnt <= '0;
        else if (cnt == TERM) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == TERM);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Duty-cycle sequencer for one PWM motor channel: soft start/stop, reversal
// through a dead time at zero duty, brake and emergency stop.
// Optional build macro MOTOR_DUTY_CLAMP_EN: clamps targets to MAX_DUTY.
module motor_ramp_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int LENGTH     = DEF_LENGTH,
    parameter int STEP       = 4,
    parameter int TICK_DIV   = 1000,
    parameter int DEAD_TICKS = 8,
    parameter int MAX_DUTY   = (1 << LENGTH) - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LENGTH-1:0] cmd_duty,
    input  logic              cmd_dir,
    input  logic              cmd_brake,
    input  logic              estop,
    output logic [LENGTH-1:0] duty,
    output logic              dir,
    output logic              brake,
    output logic              busy,
    output logic              at_target
);

    localparam int DW = $clog2(DEAD_TICKS + 1);
    localparam logic [LENGTH:0] STEP_W    = (LENGTH+1)'(STEP);
    localparam logic [DW-1:0]   DEAD_LAST = DW'(DEAD_TICKS - 1);

`ifdef MOTOR_DUTY_CLAMP_EN
    localparam logic [LENGTH-1:0] MAX_W = LENGTH'(MAX_DUTY);
    function automatic logic [LENGTH-1:0] clamp_duty(input logic [LENGTH-1:0] d);
        return (d > MAX_W) ? MAX_W : d;
    endfunction
`else
    function automatic logic [LENGTH-1:0] clamp_duty(input logic [LENGTH-1:0] d);
        return d;
    endfunction
    logic [31:0] unused_max_duty;
    assign unused_max_duty = 32'(MAX_DUTY);
`endif

    state_t            state, state_n;
    logic [LENGTH-1:0] duty_n, target, target_n, pend_duty, pend_duty_n;
    logic              dir_n, brake_n, pend_dir, pend_dir_n;
    logic [DW-1:0]     dead_cnt, dead_cnt_n;
    logic              ready_q;
    logic [LENGTH:0]   diff;
    logic              tick;

    ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Ready is registered from state; estop gates it combinationally so a
    // command can never slip in while the stop is held.
    assign cmd_ready = ready_q & ~estop;

    // Next-state: command first, then slew toward the (possibly new) target,
    // then the reversal / dead-time / idle transitions.
    always_comb begin
        state_n     = state;
        duty_n      = duty;
        dir_n       = dir;
        brake_n     = brake;
        target_n    = target;
        pend_duty_n = pend_duty;
        pend_dir_n  = pend_dir;
        dead_cnt_n  = dead_cnt;
        diff        = '0;

        if (estop) begin
            duty_n   = '0;
            brake_n  = 1'b1;
            target_n = '0;
            state_n  = ST_BRAKE;
        end else begin
            if (cmd_valid && cmd_ready) begin
                if (cmd_brake) begin
                    duty_n   = '0;
                    brake_n  = 1'b1;
                    target_n = '0;
                    state_n  = ST_BRAKE;
                end else begin
                    brake_n = 1'b0;
                    if (cmd_dir == dir || duty == '0) begin
                        // Same direction, or stopped: direction may change now.
                        dir_n    = cmd_dir;
                        target_n = clamp_duty(cmd_duty);
                        state_n  = ST_RUN;
                    end else begin
                        pend_dir_n  = cmd_dir;
                        pend_duty_n = clamp_duty(cmd_duty);
                        target_n    = '0;
                        state_n     = ST_REV_DOWN;
                    end
                end
            end

            if (tick && (state_n == ST_RUN || state_n == ST_REV_DOWN)) begin
                if (duty_n < target_n) begin
                    diff   = {1'b0, target_n} - {1'b0, duty_n};
                    duty_n = LENGTH'({1'b0, duty_n} + ((diff < STEP_W) ? diff : STEP_W));
                end else if (duty_n > target_n) begin
                    diff   = {1'b0, duty_n} - {1'b0, target_n};
                    duty_n = LENGTH'({1'b0, duty_n} - ((diff < STEP_W) ? diff : STEP_W));
                end
            end

            if (state_n == ST_REV_DOWN && duty_n == '0) begin
                state_n    = ST_DEAD;
                dead_cnt_n = '0;
            end else if (state == ST_DEAD && tick) begin
                if (dead_cnt == DEAD_LAST) begin
                    dir_n    = pend_dir;
                    target_n = pend_duty;
                    state_n  = ST_RUN;
                end else begin
                    dead_cnt_n = dead_cnt + 1'b1;
                end
            end

            if (state_n == ST_RUN && target_n == '0 && duty_n == '0)
                state_n = ST_IDLE;
        end
    end

    // State and registered outputs; status flags derived from next values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            duty      <= '0;
            dir       <= DIR_FWD;
            brake     <= 1'b0;
            target    <= '0;
            pend_duty <= '0;
            pend_dir  <= DIR_FWD;
            dead_cnt  <= '0;
            ready_q   <= 1'b0;
            busy      <= 1'b0;
            at_target <= 1'b0;
        end else begin
            state     <= state_n;
            duty      <= duty_n;
            dir       <= dir_n;
            brake     <= brake_n;
            target    <= target_n;
            pend_duty <= pend_duty_n;
            pend_dir  <= pend_dir_n;
            dead_cnt  <= dead_cnt_n;
            ready_q   <= (state_n != ST_DEAD);
            busy      <= (state_n == ST_REV_DOWN) || (state_n == ST_DEAD) ||
                         (state_n == ST_RUN && duty_n != target_n);
            at_target <= (state_n == ST_RUN) && (duty_n == target_n);
        end
    end

endmodule
